// File: rtl/race_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | race_pkg : shared state encodings and lane-slicing helpers           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package race_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_FINISH    = 2'd3
    } race_state_e;

    localparam int DEF_POS_W  = 11;
    localparam int DEF_SPD_W  = 4;
    localparam int NUM_LIGHTS = 3;

    // LSB of lane idx inside a packed per-player vector of the given width
    function automatic int lane_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/race_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | race_lane : speed, decay, position and false-start state of a player |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module race_lane #(
    parameter int POS_W        = 11,
    parameter int SPD_W        = 4,
    parameter int MAX_SPEED    = 15,
    parameter int DECAY_FRAMES = 8,
    parameter int TRACK_LEN    = 1000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             zero_i,
    input  logic             cd_en_i,
    input  logic             race_en_i,
    input  logic             accel_i,
    input  logic             frame_tick_i,
    output logic [POS_W-1:0] pos_o,
    output logic [SPD_W-1:0] speed_o,
    output logic             disq_o,
    output logic             finished_o
);

    localparam int DEC_W = $clog2(DECAY_FRAMES + 1);

    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic [POS_W:0]   pos_sum;
    logic [SPD_W-1:0] speed_q;
    logic [DEC_W-1:0] decay_q;
    logic             disq_q;

    assign pos_sum = {1'b0, pos_q} + (POS_W+1)'(speed_q);
    assign pos_d   = pos_sum[POS_W] ? '1 : pos_sum[POS_W-1:0];

    // Finish is judged on the position this tick will produce
    assign finished_o = !disq_q && (pos_d >= POS_W'(TRACK_LEN));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q   <= '0;
            speed_q <= '0;
            decay_q <= '0;
            disq_q  <= 1'b0;
        end else if (clear_i) begin
            pos_q   <= '0;
            speed_q <= '0;
            decay_q <= '0;
            disq_q  <= 1'b0;
        end else if (zero_i) begin
            pos_q   <= '0;
            speed_q <= '0;
            decay_q <= '0;
        end else begin
            if (cd_en_i && accel_i) begin
                disq_q <= 1'b1;
            end
            if (race_en_i && !disq_q) begin
                if (frame_tick_i) begin
                    pos_q <= pos_d;
                end
                if (accel_i) begin
                    decay_q <= '0;
                    if (speed_q != SPD_W'(MAX_SPEED)) begin
                        speed_q <= speed_q + SPD_W'(1);
                    end
                end else if (frame_tick_i) begin
                    if (decay_q == DEC_W'(DECAY_FRAMES - 1)) begin
                        decay_q <= '0;
                        if (speed_q != '0) begin
                            speed_q <= speed_q - SPD_W'(1);
                        end
                    end else begin
                        decay_q <= decay_q + DEC_W'(1);
                    end
                end
            end
        end
    end

    assign pos_o   = pos_q;
    assign speed_o = speed_q;
    assign disq_o  = disq_q;

endmodule
`default_nettype wire

// File: rtl/race_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | race_controller : N-player drag-race flow FSM, countdown and winner  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module race_controller
    import race_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int POS_W         = DEF_POS_W,
    parameter int SPD_W         = DEF_SPD_W,
    parameter int MAX_SPEED     = 15,
    parameter int TRACK_LEN     = 1000,
    parameter int CD_FRAMES     = 60,
    parameter int DECAY_FRAMES  = 8,
    parameter int FINISH_FRAMES = 180,
    localparam int ID_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         frame_tick_i,
    input  logic                         start_game_i,
    input  logic                         abort_i,
    input  logic [NUM_PLAYERS-1:0]       accel_i,
    output logic [1:0]                   state_o,
    output logic [NUM_LIGHTS-1:0]        lights_o,
    output logic                         go_o,
    output logic [NUM_PLAYERS*POS_W-1:0] pos_o,
    output logic [NUM_PLAYERS*SPD_W-1:0] speed_o,
    output logic [NUM_PLAYERS-1:0]       disq_o,
    output logic                         winner_valid_o,
    output logic [ID_W-1:0]              winner_id_o,
    output logic                         race_done_o
);

    localparam int TMR_MAX = (CD_FRAMES > FINISH_FRAMES) ? CD_FRAMES : FINISH_FRAMES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    race_state_e           state_q;
    logic [NUM_LIGHTS-1:0] lights_q;
    logic                  go_q;
    logic [TMR_W-1:0]      timer_q;
    logic                  winner_valid_q;
    logic [ID_W-1:0]       winner_id_q;
    logic                  race_done_q;

    logic                   clear_w;
    logic                   cd_en_w;
    logic                   race_en_w;
    logic [NUM_PLAYERS-1:0] lane_fin_w;
    logic [NUM_PLAYERS-1:0] disq_w;
    logic [ID_W-1:0]        fin_id_w;

    assign clear_w   = (state_q == ST_IDLE) && start_game_i && !abort_i;
    assign cd_en_w   = (state_q == ST_COUNTDOWN);
    assign race_en_w = (state_q == ST_RACE);

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
        race_lane #(
            .POS_W       (POS_W),
            .SPD_W       (SPD_W),
            .MAX_SPEED   (MAX_SPEED),
            .DECAY_FRAMES(DECAY_FRAMES),
            .TRACK_LEN   (TRACK_LEN)
        ) u_lane (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clear_i     (clear_w),
            .zero_i      (abort_i),
            .cd_en_i     (cd_en_w),
            .race_en_i   (race_en_w),
            .accel_i     (accel_i[i]),
            .frame_tick_i(frame_tick_i),
            .pos_o       (pos_o[lane_lsb(i, POS_W) +: POS_W]),
            .speed_o     (speed_o[lane_lsb(i, SPD_W) +: SPD_W]),
            .disq_o      (disq_w[i]),
            .finished_o  (lane_fin_w[i])
        );
    end

    // Descending scan so the lowest finishing index wins ties
    always_comb begin
        fin_id_w = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (lane_fin_w[i]) begin
                fin_id_w = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            lights_q       <= '0;
            go_q           <= 1'b0;
            timer_q        <= '0;
            winner_valid_q <= 1'b0;
            winner_id_q    <= '0;
            race_done_q    <= 1'b0;
        end else begin
            race_done_q <= 1'b0;
            if (abort_i) begin
                state_q  <= ST_IDLE;
                lights_q <= '0;
                go_q     <= 1'b0;
                timer_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_game_i) begin
                            state_q        <= ST_COUNTDOWN;
                            timer_q        <= '0;
                            lights_q       <= '0;
                            winner_valid_q <= 1'b0;
                            winner_id_q    <= '0;
                        end
                    end
                    ST_COUNTDOWN: begin
                        if (frame_tick_i) begin
                            if (timer_q == TMR_W'(CD_FRAMES - 1)) begin
                                timer_q <= '0;
                                if (&lights_q) begin
                                    state_q  <= ST_RACE;
                                    go_q     <= 1'b1;
                                    lights_q <= '0;
                                end else begin
                                    lights_q <= {lights_q[NUM_LIGHTS-2:0], 1'b1};
                                end
                            end else begin
                                timer_q <= timer_q + TMR_W'(1);
                            end
                        end
                    end
                    ST_RACE: begin
                        if (frame_tick_i && ((|lane_fin_w) || (&disq_w))) begin
                            state_q        <= ST_FINISH;
                            go_q           <= 1'b0;
                            timer_q        <= '0;
                            race_done_q    <= 1'b1;
                            winner_valid_q <= |lane_fin_w;
                            winner_id_q    <= fin_id_w;
                        end
                    end
                    ST_FINISH: begin
                        if (frame_tick_i) begin
                            if (timer_q == TMR_W'(FINISH_FRAMES - 1)) begin
                                state_q <= ST_IDLE;
                                timer_q <= '0;
                            end else begin
                                timer_q <= timer_q + TMR_W'(1);
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign state_o        = state_q;
    assign lights_o       = lights_q;
    assign go_o           = go_q;
    assign disq_o         = disq_w;
    assign winner_valid_o = winner_valid_q;
    assign winner_id_o    = winner_id_q;
    assign race_done_o    = race_done_q;

endmodule
`default_nettype wire

// File: tb/tb_race_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_race_controller : directed self-checking bench for race_controller|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_race_controller;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        frame_tick_i;
    logic        start_game_i;
    logic        abort_i;
    logic [1:0]  accel_i;
    logic [1:0]  state_o;
    logic [2:0]  lights_o;
    logic        go_o;
    logic [21:0] pos_o;
    logic [7:0]  speed_o;
    logic [1:0]  disq_o;
    logic        winner_valid_o;
    logic        winner_id_o;
    logic        race_done_o;

    int   vectors;
    int   miscompares;
    logic rd_seen;

    race_controller #(
        .NUM_PLAYERS(2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .frame_tick_i  (frame_tick_i),
        .start_game_i  (start_game_i),
        .abort_i       (abort_i),
        .accel_i       (accel_i),
        .state_o       (state_o),
        .lights_o      (lights_o),
        .go_o          (go_o),
        .pos_o         (pos_o),
        .speed_o       (speed_o),
        .disq_o        (disq_o),
        .winner_valid_o(winner_valid_o),
        .winner_id_o   (winner_id_o),
        .race_done_o   (race_done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample outputs #1 after the edge, release pulses
    task automatic cyc(input logic tk, input logic [1:0] ac, input logic st, input logic ab);
        frame_tick_i = tk;
        accel_i      = ac;
        start_game_i = st;
        abort_i      = ab;
        @(posedge clk_i);
        #1;
        frame_tick_i = 1'b0;
        accel_i      = 2'b00;
        start_game_i = 1'b0;
        abort_i      = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_ni       = 1'b0;
        frame_tick_i = 1'b0;
        start_game_i = 1'b0;
        abort_i      = 1'b0;
        accel_i      = 2'b00;
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_state",  state_o, 0);
        chk("rst_lights", lights_o, 0);
        chk("rst_go",     go_o, 0);
        chk("rst_pos",    pos_o, 0);
        chk("rst_speed",  speed_o, 0);
        chk("rst_disq",   disq_o, 0);
        chk("rst_wvalid", winner_valid_o, 0);
        chk("rst_done",   race_done_o, 0);

        // Full countdown with no presses
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("cd_state", state_o, 1);
        chk("cd_lights0", lights_o, 0);
        rd_seen = 1'b0;
        for (int t = 1; t <= 240; t++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0);
            rd_seen = rd_seen | race_done_o;
            if (t == 59)  chk("cd_l59", lights_o, 3'b000);
            if (t == 60)  chk("cd_l60", lights_o, 3'b001);
            if (t == 119) chk("cd_l119", lights_o, 3'b001);
            if (t == 120) chk("cd_l120", lights_o, 3'b011);
            if (t == 180) chk("cd_l180", lights_o, 3'b111);
            if (t == 239) begin
                chk("cd_l239", lights_o, 3'b111);
                chk("cd_s239", state_o, 1);
            end
            if (t == 240) begin
                chk("race_state", state_o, 2);
                chk("race_go", go_o, 1);
                chk("race_lights", lights_o, 0);
            end
        end
        chk("cd_no_done", rd_seen, 0);

        // Build pos=[120,80]; eighth tick also exercises decay on both lanes
        for (int k = 0; k < 15; k++) cyc(1'b0, (k < 10) ? 2'b11 : 2'b01, 1'b0, 1'b0);
        chk("spd_build", speed_o, {4'd10, 4'd15});
        for (int t = 1; t <= 8; t++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0);
            if (t == 7) begin
                chk("pos_t7", pos_o, {11'd70, 11'd105});
                chk("spd_t7", speed_o, {4'd10, 4'd15});
            end
            if (t == 8) begin
                chk("pos_t8", pos_o, {11'd80, 11'd120});
                chk("spd_t8", speed_o, {4'd9, 4'd14});
            end
        end

        // Asynchronous reset mid-race, away from the clock edge
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_pos",   pos_o, 0);
        chk("arst_speed", speed_o, 0);
        chk("arst_go",    go_o, 0);
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("arst_rel_state", state_o, 0);
        chk("arst_rel_pos",   pos_o, 0);

        // False start by player 1, player 0 wins alone
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        cyc(1'b0, 2'b10, 1'b0, 1'b0);
        chk("fs_disq",  disq_o, 2'b10);
        chk("fs_speed", speed_o, 0);
        for (int t = 1; t <= 240; t++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
        chk("fs_race", state_o, 2);
        for (int k = 0; k < 20; k++) cyc(1'b0, 2'b11, 1'b0, 1'b0);
        chk("fs_sat", speed_o, {4'd0, 4'd15});
        for (int t = 1; t <= 67; t++) begin
            cyc(1'b1, 2'b01, 1'b0, 1'b0);
            if (t == 66) begin
                chk("fs_pos66", pos_o, {11'd0, 11'd990});
                chk("fs_st66", state_o, 2);
            end
            if (t == 67) begin
                chk("fs_st67",  state_o, 3);
                chk("fs_pos67", pos_o, {11'd0, 11'd1005});
                chk("fs_wv",    winner_valid_o, 1);
                chk("fs_wid",   winner_id_o, 0);
                chk("fs_done",  race_done_o, 1);
                chk("fs_go",    go_o, 0);
            end
        end
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        chk("fs_done_pulse", race_done_o, 0);
        cyc(1'b1, 2'b01, 1'b0, 1'b0);
        chk("fin_frz_spd", speed_o, {4'd0, 4'd15});
        chk("fin_frz_pos", pos_o, {11'd0, 11'd1005});
        for (int t = 1; t <= 178; t++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
        chk("fin_hold", state_o, 3);
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        chk("fin_idle", state_o, 0);
        chk("fin_wv_hold", winner_valid_o, 1);
        chk("fin_disq_hold", disq_o, 2'b10);

        // Dead heat: lower index wins
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("tie_disq_clr", disq_o, 0);
        chk("tie_wv_clr", winner_valid_o, 0);
        for (int t = 1; t <= 240; t++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) cyc(1'b0, 2'b11, 1'b0, 1'b0);
        for (int t = 1; t <= 67; t++) begin
            cyc(1'b1, 2'b11, 1'b0, 1'b0);
            if (t == 67) begin
                chk("tie_state", state_o, 3);
                chk("tie_pos",   pos_o, {11'd1005, 11'd1005});
                chk("tie_wid",   winner_id_o, 0);
                chk("tie_wv",    winner_valid_o, 1);
                chk("tie_done",  race_done_o, 1);
            end
        end
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        chk("tie_done_w", race_done_o, 0);
        cyc(1'b0, 2'b00, 1'b0, 1'b1);
        chk("ab_fin_state", state_o, 0);
        chk("ab_fin_pos",   pos_o, 0);
        chk("ab_fin_speed", speed_o, 0);
        chk("ab_fin_wv",    winner_valid_o, 1);

        // Decay and accel coinciding with a tick
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        for (int t = 1; t <= 240; t++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 2'b01, 1'b0, 1'b0);
        chk("dec_spd5", speed_o, 5);
        for (int t = 1; t <= 8; t++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0);
            if (t == 7) begin
                chk("dec_pos7", pos_o, 35);
                chk("dec_spd7", speed_o, 5);
            end
            if (t == 8) begin
                chk("dec_pos8", pos_o, 40);
                chk("dec_spd8", speed_o, 4);
            end
        end
        cyc(1'b1, 2'b01, 1'b0, 1'b0);
        chk("acc_tick_pos", pos_o, 44);
        chk("acc_tick_spd", speed_o, 5);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("start_ign_state", state_o, 2);
        chk("start_ign_pos", pos_o, 44);
        cyc(1'b0, 2'b00, 1'b0, 1'b1);
        chk("ab_race_state", state_o, 0);
        chk("ab_race_pos", pos_o, 0);

        // Abort mid-countdown then restart from a clean timer
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        for (int t = 1; t <= 130; t++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0);
            if (t == 120) chk("abcd_l120", lights_o, 3'b011);
        end
        cyc(1'b0, 2'b00, 1'b0, 1'b1);
        chk("abcd_state", state_o, 0);
        chk("abcd_lights", lights_o, 0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("recd_state", state_o, 1);
        chk("recd_lights", lights_o, 0);
        for (int t = 1; t <= 60; t++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0);
            if (t == 59) chk("recd_l59", lights_o, 3'b000);
            if (t == 60) chk("recd_l60", lights_o, 3'b001);
        end

        // Everyone jumps the start: race ends on the first race tick, no winner
        cyc(1'b0, 2'b11, 1'b0, 1'b0);
        chk("alld_disq", disq_o, 2'b11);
        for (int t = 1; t <= 180; t++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
        chk("alld_race", state_o, 2);
        chk("alld_go", go_o, 1);
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        chk("alld_fin", state_o, 3);
        chk("alld_wv", winner_valid_o, 0);
        chk("alld_done", race_done_o, 1);
        chk("alld_pos", pos_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
